// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO.
// MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; MTHI/MTLO write in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath: acc_hi/acc_lo hold product halves or remainder/quotient.
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] src_q, src_d;

  logic             in_neg_a, in_neg_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign in_neg_a  = ~op[0] & rs_data[WIDTH-1];
  assign in_neg_b  = ~op[0] & rt_data[WIDTH-1];

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand_q};

  assign prod_mag  = {acc_hi_q, acc_lo_q};
  assign prod_fix  = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
  assign quo_fix   = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix   = neg_a_q ? -acc_hi_q : acc_hi_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    src_d    = src_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = op[1];
              neg_a_d  = in_neg_a;
              neg_b_d  = in_neg_b;
              acc_lo_d = in_neg_a ? -rs_data : rs_data;
              mcand_d  = in_neg_b ? -rt_data : rt_data;
              acc_hi_d = '0;
              src_d    = rs_data;
              cnt_d    = '0;
              state_d  = S_RUN;
            end
            3'b100:  hi_d = rs_data;
            3'b101:  lo_d = rs_data;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_hi_d = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q}) : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        // Divide by zero bypasses sign fix-up: HI is the raw dividend, LO all ones.
        if (is_div_q && (mcand_q == '0)) begin
          hi_d = src_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: operand/accumulator registers need no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    neg_a_q  <= neg_a_d;
    neg_b_q  <= neg_b_d;
    mcand_q  <= mcand_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    src_q    <= src_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
